instr_prefetch_unit: RTL and testbench
======================================

Name: instr_prefetch_unit

Overview:
- Fetch stage that sits directly upstream of the CPU's decode/register-file logic.
- Issues word fetches to a multi-cycle instruction memory over a req/ack handshake and buffers the returned instructions with their PC and PC+4 in a small FIFO.
- Delivers instructions to the CPU through a valid/ready handshake.
- Flushes and refetches on a branch, jump or jr redirect from the execute logic.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk_i, input, 1, clock; all state updates on the rising edge.
- rst_i, input, 1, asynchronous reset, active-high.
- mem_req_o, output, 1, fetch request; held high until acknowledged.
- mem_addr_o, output, 32, word address; stable while mem_req_o is high; bits [1:0] are always 0.
- mem_ack_i, input, 1, single-cycle acknowledge; mem_data_i is valid in the same cycle.
- mem_data_i, input, 32, fetched instruction word.
- instr_valid_o, output, 1, FIFO head is valid.
- instr_o, output, 32, head instruction.
- instr_pc_o, output, 32, address of the head instruction.
- instr_pc4_o, output, 32, instr_pc_o + 4; used for the branch adder and jal link.
- instr_ready_i, input, 1, the CPU consumes the head when instr_valid_o && instr_ready_i.
- redirect_i, input, 1, branch taken, jump or jr.
- redirect_pc_i, input, 32, new fetch PC; bits [1:0] are ignored and forced to 0.
- count_o, output, $clog2(DEPTH)+1, current FIFO occupancy.

Behaviour:
- Reset (asynchronous, rst_i=1):
  - FSM goes to IDLE, fetch_pc=RESET_PC, FIFO is empty.
  - All outputs are 0: mem_req_o, mem_addr_o, instr_valid_o, instr_o, instr_pc_o, instr_pc4_o, count_o.
  - The same applies when reset is asserted mid-request. A pending ack is abandoned, and the memory is required to tolerate a dropped req.
- FSM states: IDLE, REQ, DISCARD. mem_req_o is a registered signal, equal to (state != IDLE).
- IDLE:
  - Moves to REQ when count_o < DEPTH after this cycle's pop.
  - mem_addr_o <= fetch_pc.
  - Only one request is ever outstanding.
- REQ:
  - mem_ack_i is sampled only while mem_req_o=1; an ack seen while mem_req_o=0 is ignored.
  - On ack: push {mem_data_i, mem_addr_o}, then fetch_pc <= mem_addr_o + 4 (modulo 2^32, so 32'hFFFF_FFFC wraps to 0).
  - After the ack: go back to REQ with the new address if space remains after this cycle's push and pop; otherwise go to IDLE.
  - The request is issued only when a slot is guaranteed, so a push never overflows.
- DISCARD:
  - Holds mem_req_o and mem_addr_o until ack, then drops the data without pushing it.
  - After the ack, moves to REQ at fetch_pc, or to IDLE if the FIFO is full. It cannot be full after a flush, so it goes to REQ.
- Redirect has the highest priority:
  - FIFO flushes: count_o=0 and instr_valid_o=0 next cycle. Any same-cycle pop or push is cancelled.
  - fetch_pc <= {redirect_pc_i[31:2], 2'b00}.
  - From IDLE: go to REQ.
  - From REQ without a same-cycle ack: go to DISCARD.
  - From REQ with a same-cycle ack: the data is dropped and the FSM goes to REQ at the new PC.
  - In DISCARD: fetch_pc is updated again and the FSM stays in DISCARD, or goes to REQ if the ack arrives this cycle.
- Latency:
  - mem_req_o rises on the first edge after reset is released.
  - An ack in cycle k gives instr_valid_o=1 in cycle k+1.
  - A redirect in cycle k gives the new request address in cycle k+1.
- FIFO:
  - Simultaneous push and pop leaves count unchanged.
  - Pop on empty is ignored.
  - When empty, instr_o, instr_pc_o and instr_pc4_o read 0 (NOP).
  - Head outputs are driven from registered storage through a read mux; there is no combinational path from mem_data_i.

Decomposition:
- Shared package:
  - Fetch FSM state enum (IDLE/REQ/DISCARD).
  - INSTR_W=32, ADDR_W=32.
  - NOP_INSTR=32'h0.
  - Fetch-entry struct {instr, pc}.
- Sub-module prefetch_fifo: synchronous FIFO with flush_i, push_i, pop_i, count_o and head-read outputs; parameterised by DEPTH and entry width.

Test Plan:
- Reset, then memory acks 2 cycles after each request with data = addr ^ 32'hA5A5_0000, instr_ready_i=1 → addresses 0,4,8,… in order; instr_pc4_o = instr_pc_o + 4; no gaps beyond memory latency.
- instr_ready_i=0, ack in 1 cycle, DEPTH=4 → exactly 4 pushes; count_o=4; mem_req_o=0 (IDLE). Raise ready for one cycle → one pop, then the next request goes to 0x10.
- Redirect to 0x0000_0103 while in REQ with no ack, ack 3 cycles later → that data is discarded; next request addr=0x0000_0100; FIFO empty meanwhile.
- Redirect and ack in the same cycle, with a pop pending → no push, no pop; count_o=0; next mem_addr_o = redirect target.
- RESET_PC=32'hFFFF_FFF8 → fetches 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000 (wrap).
- Assert rst_i mid-REQ asynchronously, between clock edges → all outputs 0 immediately; after release the first request goes to RESET_PC.

Source files
------------

// File: rtl/instr_prefetch_unit_pkg.sv
// Shared types and constants for the instruction prefetch unit.
package instr_prefetch_unit_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    // An empty fetch buffer presents this word on its head outputs.
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    // Fetch FSM: idle, one request in flight, or one stale request being drained.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_state_e;

    // One buffered instruction together with the address it was fetched from.
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } fetch_entry_t;

    // Instruction fetches are always word aligned.
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_prefetch_unit_prefetch_fifo.sv
// Synchronous FIFO with flush; the head reads as all-zero when empty.
module prefetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic                     head_valid_o,
    output logic [WIDTH-1:0]         head_data_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             empty;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    // Popping an empty FIFO is a no-op; a push into a full FIFO only lands if a pop frees a slot.
    assign do_pop  = pop_i && !empty;
    assign do_push = push_i && (!full || do_pop);

    // Pointer and occupancy tracking; flush wins over any same-cycle push or pop.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Entry storage write port.
    // NOTE: storage has no reset; the empty-gated read mux keeps stale contents invisible.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_valid_o = !empty;
    assign head_data_o  = empty ? '0 : mem_q[rd_ptr_q];
    assign count_o      = count_q;

endmodule

// File: rtl/instr_prefetch_unit.sv
// Fetch stage: single-outstanding req/ack fetcher feeding a small instruction FIFO.
module instr_prefetch_unit
    import instr_prefetch_unit_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    output logic                     mem_req_o,
    output logic [ADDR_W-1:0]        mem_addr_o,
    input  logic                     mem_ack_i,
    input  logic [INSTR_W-1:0]       mem_data_i,
    output logic                     instr_valid_o,
    output logic [INSTR_W-1:0]       instr_o,
    output logic [ADDR_W-1:0]        instr_pc_o,
    output logic [ADDR_W-1:0]        instr_pc4_o,
    input  logic                     instr_ready_i,
    input  logic                     redirect_i,
    input  logic [ADDR_W-1:0]        redirect_pc_i,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    fetch_state_e      state_q, state_d;
    logic              req_q;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] redirect_target;
    logic [ADDR_W-1:0] next_addr;
    logic              ack;
    logic              do_push;
    logic              do_pop;
    logic              has_space;
    logic [CNT_W-1:0]  count_after;
    logic              head_valid;
    fetch_entry_t      push_entry;
    fetch_entry_t      head_entry;

    assign redirect_target = word_align(redirect_pc_i);
    assign next_addr       = addr_q + ADDR_W'(4);
    // An ack only counts while a request is actually on the bus.
    assign ack             = mem_ack_i && req_q;
    // A redirect cancels both sides of the FIFO for this cycle.
    assign do_pop          = head_valid && instr_ready_i && !redirect_i;
    assign do_push         = (state_q == ST_REQ) && ack && !redirect_i;
    assign count_after     = count_o + CNT_W'(do_push) - CNT_W'(do_pop);
    // A new request is only issued when its data is guaranteed a slot.
    assign has_space       = (count_after < CNT_W'(DEPTH));

    // Fetch sequencing: next state, next request address and next sequential PC.
    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (redirect_i) begin
                    state_d    = ST_REQ;
                    fetch_pc_d = redirect_target;
                    addr_d     = redirect_target;
                end else begin
                    addr_d = fetch_pc_q;
                    if (has_space) state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (redirect_i) begin
                    fetch_pc_d = redirect_target;
                    if (ack) addr_d  = redirect_target;
                    else     state_d = ST_DISCARD;
                end else if (ack) begin
                    fetch_pc_d = next_addr;
                    if (has_space) addr_d  = next_addr;
                    else           state_d = ST_IDLE;
                end
            end
            ST_DISCARD: begin
                if (redirect_i) begin
                    fetch_pc_d = redirect_target;
                    if (ack) begin
                        state_d = ST_REQ;
                        addr_d  = redirect_target;
                    end
                end else if (ack) begin
                    if (has_space) begin
                        state_d = ST_REQ;
                        addr_d  = fetch_pc_q;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Fetch state, request strobe and address registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            req_q      <= 1'b0;
            fetch_pc_q <= RESET_PC;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= (state_d != ST_IDLE);
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
        end
    end

    assign mem_req_o  = req_q;
    assign mem_addr_o = addr_q;

    assign push_entry = '{instr: mem_data_i, pc: addr_q};

    prefetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .flush_i      (redirect_i),
        .push_i       (do_push),
        .push_data_i  (push_entry),
        .pop_i        (do_pop),
        .head_valid_o (head_valid),
        .head_data_o  (head_entry),
        .count_o      (count_o)
    );

    assign instr_valid_o = head_valid;
    assign instr_o       = head_valid ? head_entry.instr : NOP_INSTR;
    assign instr_pc_o    = head_entry.pc;
    assign instr_pc4_o   = head_valid ? head_entry.pc + ADDR_W'(4) : '0;

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Self-checking bench: random memory latency / ready / redirect stimulus against a transaction-level scoreboard.
module tb_instr_prefetch_unit;
    import instr_prefetch_unit_pkg::*;

    localparam int          DEPTH   = 4;
    localparam logic [31:0] KEY     = 32'hA5A5_0000;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Main DUT signals
    logic        rst_i, mem_req_o, mem_ack_i, instr_valid_o, instr_ready_i, redirect_i;
    logic [31:0] mem_addr_o, mem_data_i, instr_o, instr_pc_o, instr_pc4_o, redirect_pc_i;
    logic [2:0]  count_o;

    // Wrap-around DUT signals
    logic        w_rst, w_req, w_ack, w_valid;
    logic [31:0] w_addr, w_data, w_instr, w_pc, w_pc4;
    logic [2:0]  w_count;

    instr_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
        .instr_valid_o(instr_valid_o), .instr_o(instr_o), .instr_pc_o(instr_pc_o), .instr_pc4_o(instr_pc4_o),
        .instr_ready_i(instr_ready_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .count_o(count_o)
    );

    instr_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(WRAP_PC)) dut_w (
        .clk_i(clk_i), .rst_i(w_rst),
        .mem_req_o(w_req), .mem_addr_o(w_addr), .mem_ack_i(w_ack), .mem_data_i(w_data),
        .instr_valid_o(w_valid), .instr_o(w_instr), .instr_pc_o(w_pc), .instr_pc4_o(w_pc4),
        .instr_ready_i(1'b1), .redirect_i(1'b0), .redirect_pc_i(32'h0),
        .count_o(w_count)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got timeout, want event (t=%0t)", name, $time);
    endtask

    task automatic step();
        @(posedge clk_i);
        #2;
    endtask

    // ---------------- memory responder for the main DUT ----------------
    int mem_lat     = 2;
    int wait_cnt    = 0;
    bit spurious_en = 1'b0;

    initial begin
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        forever begin
            @(posedge clk_i);
            #1;
            if (rst_i) begin
                mem_ack_i = 1'b0;
                wait_cnt  = 0;
            end else begin
                if (mem_ack_i) begin
                    mem_ack_i = 1'b0;
                    wait_cnt  = 0;
                end
                mem_data_i = $urandom();
                if (mem_req_o) begin
                    if (wait_cnt >= mem_lat) begin
                        mem_ack_i  = 1'b1;
                        mem_data_i = mem_addr_o ^ KEY;
                    end else begin
                        wait_cnt++;
                    end
                end else begin
                    wait_cnt = 0;
                    if (spurious_en && $urandom_range(0, 3) == 0) mem_ack_i = 1'b1;
                end
            end
        end
    end

    // ---------------- scoreboard / monitor ----------------
    // Model: the CPU should see the program-order stream starting at the reset PC or the last
    // redirect target, each word carrying memory content addr ^ KEY. A request outstanding at a
    // redirect (not acked that same cycle) returns stale data which must never be delivered.
    fetch_entry_t exp_q[$];
    fetch_entry_t e;
    logic [31:0]  model_pc   = '0;
    bit           stale      = 1'b0;
    bit           prev_hold  = 1'b0;
    logic [31:0]  prev_addr  = '0;
    int           n_pushes   = 0;
    int           n_consumed = 0;

    initial begin
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                exp_q.delete();
                model_pc  = '0;
                stale     = 1'b0;
                prev_hold = 1'b0;
                n_pushes  = 0;
                continue;
            end
            check("count_vs_model", 32'(count_o), 32'(exp_q.size()));
            check("valid_vs_model", 32'(instr_valid_o), 32'(exp_q.size() != 0));
            if (exp_q.size() == 0) begin
                check("empty_instr_nop", instr_o, 32'h0);
                check("empty_pc_zero", instr_pc_o, 32'h0);
                check("empty_pc4_zero", instr_pc4_o, 32'h0);
            end
            check("addr_aligned", 32'(mem_addr_o[1:0]), 32'h0);
            if (prev_hold) begin
                check("req_held_until_ack", 32'(mem_req_o), 32'h1);
                check("addr_stable_while_req", mem_addr_o, prev_addr);
            end
            prev_hold = mem_req_o && !mem_ack_i;
            prev_addr = mem_addr_o;

            if (redirect_i) begin
                exp_q.delete();
                model_pc = {redirect_pc_i[31:2], 2'b00};
                stale    = mem_req_o && !mem_ack_i;
            end else begin
                if (instr_valid_o && instr_ready_i) begin
                    if (exp_q.size() == 0) begin
                        check("pop_with_model_empty", 32'(exp_q.size()), 32'h1);
                    end else begin
                        e = exp_q.pop_front();
                        check("head_instr", instr_o, e.instr);
                        check("head_pc", instr_pc_o, e.pc);
                        check("head_pc4", instr_pc4_o, e.pc + 32'd4);
                        n_consumed++;
                    end
                end
                if (mem_ack_i && mem_req_o) begin
                    if (stale) begin
                        stale = 1'b0;
                    end else begin
                        check("req_addr_in_order", mem_addr_o, model_pc);
                        exp_q.push_back('{instr: model_pc ^ KEY, pc: model_pc});
                        model_pc = model_pc + 32'd4;
                        n_pushes++;
                    end
                end
            end
        end
    end

    // ---------------- wrap-around instance: zero-latency memory, always ready ----------------
    logic [31:0] w_req_addrs[$];
    logic [31:0] w_pcs[$];
    logic [31:0] w_pc4s[$];

    initial begin
        w_ack  = 1'b0;
        w_data = '0;
        forever begin
            @(posedge clk_i);
            #1;
            w_ack  = !w_rst && w_req && !w_ack;
            w_data = w_addr ^ KEY;
        end
    end

    always @(negedge clk_i) begin
        if (!w_rst) begin
            if (w_req && w_ack) w_req_addrs.push_back(w_addr);
            if (w_valid) begin
                w_pcs.push_back(w_pc);
                w_pc4s.push_back(w_pc4);
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed + random stimulus ----------------
    initial begin
        int          acks;
        int          c0;
        logic [31:0] old_addr;

        rst_i         = 1'b1;
        w_rst         = 1'b1;
        instr_ready_i = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;

        // Reset state
        step();
        step();
        check("rst_req", 32'(mem_req_o), 32'h0);
        check("rst_addr", mem_addr_o, 32'h0);
        check("rst_valid", 32'(instr_valid_o), 32'h0);
        check("rst_instr", instr_o, 32'h0);
        check("rst_pc", instr_pc_o, 32'h0);
        check("rst_pc4", instr_pc4_o, 32'h0);
        check("rst_count", 32'(count_o), 32'h0);

        // Sequential fetch, latency 2, CPU always ready
        instr_ready_i = 1'b1;
        mem_lat       = 2;
        rst_i         = 1'b0;
        step();
        check("req_first_edge_after_reset", 32'(mem_req_o), 32'h1);
        check("first_addr_is_reset_pc", mem_addr_o, 32'h0);
        acks = 0;
        for (int i = 0; i < 30; i++) begin
            if (mem_ack_i) acks++;
            step();
        end
        check("seq_ack_every_3_cycles", 32'(acks), 32'd10);
        check("seq_instrs_delivered", 32'(n_consumed >= 9), 32'h1);

        // Fill to full with CPU stalled, latency 1
        rst_i         = 1'b1;
        instr_ready_i = 1'b0;
        mem_lat       = 1;
        step();
        step();
        rst_i = 1'b0;
        step();
        for (int i = 0; i < 60 && !(count_o == 3'd4 && !mem_req_o); i++) step();
        if (!(count_o == 3'd4 && !mem_req_o)) fail_timeout("fill_to_full");
        repeat (3) step();
        check("full_count", 32'(count_o), 32'd4);
        check("full_idle_no_req", 32'(mem_req_o), 32'h0);
        check("full_exactly_4_pushes", 32'(n_pushes), 32'd4);
        check("full_head_pc", instr_pc_o, 32'h0);
        check("full_head_instr", instr_o, KEY);
        instr_ready_i = 1'b1;
        step();
        instr_ready_i = 1'b0;
        check("after_pop_count", 32'(count_o), 32'd3);
        check("after_pop_req", 32'(mem_req_o), 32'h1);
        check("after_pop_addr", mem_addr_o, 32'h10);
        check("after_pop_head_pc", instr_pc_o, 32'h4);

        // Redirect while a request is in flight without an ack: stale data dropped
        instr_ready_i = 1'b1;
        mem_lat       = 3;
        for (int i = 0; i < 40 && !(mem_req_o && !mem_ack_i && wait_cnt == 1); i++) step();
        if (!(mem_req_o && !mem_ack_i && wait_cnt == 1)) fail_timeout("discard_setup");
        old_addr      = mem_addr_o;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0103;
        step();
        redirect_i = 1'b0;
        check("discard_flush_count", 32'(count_o), 32'h0);
        check("discard_flush_valid", 32'(instr_valid_o), 32'h0);
        check("discard_req_held", 32'(mem_req_o), 32'h1);
        check("discard_addr_held", mem_addr_o, old_addr);
        for (int i = 0; i < 10 && !mem_ack_i; i++) step();
        if (!mem_ack_i) fail_timeout("discard_ack");
        step();
        check("after_discard_req", 32'(mem_req_o), 32'h1);
        check("after_discard_addr", mem_addr_o, 32'h0000_0100);
        check("after_discard_count", 32'(count_o), 32'h0);

        // Redirect coinciding with an ack and a pending pop
        instr_ready_i = 1'b0;
        mem_lat       = 1;
        for (int i = 0; i < 40 && !(mem_ack_i && mem_req_o && count_o != 0); i++) step();
        if (!(mem_ack_i && mem_req_o && count_o != 0)) fail_timeout("redirect_ack_setup");
        instr_ready_i = 1'b1;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_2000;
        step();
        redirect_i = 1'b0;
        check("redir_ack_count", 32'(count_o), 32'h0);
        check("redir_ack_valid", 32'(instr_valid_o), 32'h0);
        check("redir_ack_req", 32'(mem_req_o), 32'h1);
        check("redir_ack_addr", mem_addr_o, 32'h0000_2000);
        repeat (10) step();

        // Asynchronous reset between clock edges while a request is pending
        for (int i = 0; i < 10 && !mem_req_o; i++) step();
        if (!mem_req_o) fail_timeout("async_rst_setup");
        #1;
        rst_i = 1'b1;
        #1;
        check("async_rst_req", 32'(mem_req_o), 32'h0);
        check("async_rst_addr", mem_addr_o, 32'h0);
        check("async_rst_valid", 32'(instr_valid_o), 32'h0);
        check("async_rst_instr", instr_o, 32'h0);
        check("async_rst_pc", instr_pc_o, 32'h0);
        check("async_rst_pc4", instr_pc4_o, 32'h0);
        check("async_rst_count", 32'(count_o), 32'h0);
        step();
        step();
        rst_i = 1'b0;
        step();
        check("post_rst_req", 32'(mem_req_o), 32'h1);
        check("post_rst_addr", mem_addr_o, 32'h0);

        // Address wrap from a reset PC near the top of the address space
        w_rst = 1'b0;
        repeat (12) step();
        if (w_req_addrs.size() >= 3 && w_pcs.size() >= 3) begin
            check("wrap_addr0", w_req_addrs[0], 32'hFFFF_FFF8);
            check("wrap_addr1", w_req_addrs[1], 32'hFFFF_FFFC);
            check("wrap_addr2", w_req_addrs[2], 32'h0000_0000);
            check("wrap_pc2", w_pcs[2], 32'h0000_0000);
            check("wrap_pc4_0", w_pc4s[0], 32'hFFFF_FFFC);
            check("wrap_pc4_1", w_pc4s[1], 32'h0000_0000);
        end else begin
            fail_timeout("wrap_fetches");
        end

        // Randomised traffic: latency, backpressure, redirects and stray acks
        spurious_en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            instr_ready_i = ($urandom_range(0, 3) != 0);
            mem_lat       = $urandom_range(0, 3);
            redirect_i    = ($urandom_range(0, 24) == 0);
            redirect_pc_i = $urandom();
            step();
        end
        redirect_i    = 1'b0;
        spurious_en   = 1'b0;
        instr_ready_i = 1'b1;
        mem_lat       = 1;
        c0            = n_consumed;
        repeat (30) step();
        check("random_progress", 32'(n_consumed > c0), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
